pal_out_stage: RTL and testbench

PAL_OUT_STAGE -- requirements
Module: pal_out_stage

---
 rtl/pal_out_stage.sv | 138 +++++++++++++
 tb/tb_pal_out_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pal_out_stage.sv
// Palette output stage: on each pixel strobe, fetches one 16-bit colour word
// from the split upper/lower palette RAMs, decodes it into 6-bit R/G/B and
// presents it to the DAC with a one-cycle PIX_VALID pulse.
// Optional feature macro: PAL_SHADOW_EN (halves each channel when the
// pixel's latched SHADOW bit is set). Without it, SHADOW is ignored.
module pal_out_stage #(
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic        CLK_24M,
  input  logic        nRESET,
  input  logic        PIXEL_STROBE,
  input  logic [12:0] PAL_INDEX,
  input  logic        BLANK,
  input  logic        SHADOW,
  output logic [12:0] PAL_ADDR,
  output logic        PAL_nCE,
  input  logic [7:0]  PAL_DATA_U,
  input  logic [7:0]  PAL_DATA_L,
  output logic [5:0]  R,
  output logic [5:0]  G,
  output logic [5:0]  B,
  output logic        PIX_VALID,
  output logic        OVERRUN
);

  if (WAIT_CYCLES == 0 || WAIT_CYCLES > 15) begin : g_wait_range_check
    $error("pal_out_stage: WAIT_CYCLES must be in 1..15");
  end

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, FETCH, OUT} state_t;

  state_t      state;
  state_t      next_state;
  logic [3:0]  cnt;
  logic        blank_q;
  logic [15:0] word;
  logic        accept;
  logic        drop;
  logic        capture;
  logic        emit;
  logic [5:0]  r_dec;
  logic [5:0]  g_dec;
  logic [5:0]  b_dec;

`ifdef PAL_SHADOW_EN
  logic        shadow_q;
`else
  logic        unused_shadow;
  assign unused_shadow = SHADOW;
`endif

  // State register
  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (PIXEL_STROBE) next_state = FETCH;
      FETCH:   if (cnt == 4'd1)  next_state = OUT;
      OUT:     next_state = PIXEL_STROBE ? FETCH : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs; RAM enable is decoded from state so reset releases it at once
  always_comb begin
    accept  = PIXEL_STROBE && (state == IDLE || state == OUT);
    drop    = PIXEL_STROBE && (state == FETCH);
    capture = (state == FETCH) && (cnt == 4'd1);
    emit    = (state == OUT);
    PAL_nCE = !((state == FETCH) && !blank_q);
  end

  // Colour decode of the captured word; blanked pixels are forced black
  always_comb begin
    r_dec = {word[11:8], word[14], ~word[15]};
    g_dec = {word[7:4],  word[13], ~word[15]};
    b_dec = {word[3:0],  word[12], ~word[15]};
`ifdef PAL_SHADOW_EN
    if (shadow_q) begin
      r_dec = r_dec >> 1;
      g_dec = g_dec >> 1;
      b_dec = b_dec >> 1;
    end
`endif
    if (blank_q) begin
      r_dec = '0;
      g_dec = '0;
      b_dec = '0;
    end
  end

  // Access datapath: address/flag latch, wait counter, word capture, output regs
  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      PAL_ADDR  <= '0;
      cnt       <= '0;
      blank_q   <= 1'b0;
      word      <= '0;
      R         <= '0;
      G         <= '0;
      B         <= '0;
      PIX_VALID <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      PIX_VALID <= emit;
      if (emit) begin
        R <= r_dec;
        G <= g_dec;
        B <= b_dec;
      end
      if (accept) begin
        PAL_ADDR <= PAL_INDEX;
        blank_q  <= BLANK;
        cnt      <= WAIT_LOAD;
      end else if (state == FETCH) begin
        cnt <= cnt - 4'd1;
      end
      if (capture) word <= blank_q ? 16'h0000 : {PAL_DATA_U, PAL_DATA_L};
      if (drop) OVERRUN <= 1'b1;
    end
  end

`ifdef PAL_SHADOW_EN
  // Shadow flag travels with the pixel like BLANK
  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET)     shadow_q <= 1'b0;
    else if (accept) shadow_q <= SHADOW;
  end
`endif

endmodule

// File: tb/tb_pal_out_stage.sv
// Directed bench for pal_out_stage with default WAIT_CYCLES (3).
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_pal_out_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        strobe;
  logic [12:0] index;
  logic        blank;
  logic        shadow;
  logic [12:0] addr;
  logic        n_ce;
  logic [7:0]  data_u;
  logic [7:0]  data_l;
  logic [5:0]  r, g, b;
  logic        pix_valid;
  logic        overrun;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pal_out_stage #(.WAIT_CYCLES(3)) dut (
    .CLK_24M(clk), .nRESET(rst_n), .PIXEL_STROBE(strobe), .PAL_INDEX(index),
    .BLANK(blank), .SHADOW(shadow), .PAL_ADDR(addr), .PAL_nCE(n_ce),
    .PAL_DATA_U(data_u), .PAL_DATA_L(data_l), .R(r), .G(g), .B(b),
    .PIX_VALID(pix_valid), .OVERRUN(overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one strobe and observe edges 0..5 counted from the strobe edge.
  task automatic run_pixel(input logic [12:0] idx, input logic [7:0] u, input logic [7:0] l,
                           input logic bl, input logic sh,
                           output int nce_low, output int pv_cnt, output int pv_edge,
                           output logic [12:0] a, output logic [5:0] ro, output logic [5:0] go,
                           output logic [5:0] bo);
    nce_low = 0; pv_cnt = 0; pv_edge = -1; a = '0; ro = '0; go = '0; bo = '0;
    index = idx; data_u = u; data_l = l; blank = bl; shadow = sh; strobe = 1'b1;
    for (int e = 0; e < 6; e++) begin
      tick();
      if (e == 0) begin
        strobe = 1'b0;
        a = addr;
      end
      if (n_ce == 1'b0) nce_low++;
      if (pix_valid) begin
        pv_cnt++;
        pv_edge = e;
        ro = r; go = g; bo = b;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; strobe = 1'b0; index = '0; blank = 1'b0; shadow = 1'b0;
    data_u = '0; data_l = '0;
    tick(); tick();
    vectors++;
    if ({addr, n_ce, r, g, b, pix_valid, overrun} !== {13'h0, 1'b1, 18'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: got addr=%h nce=%b rgb=%h/%h/%h pv=%b ovr=%b, want 0/1/0/0/0/0/0",
               addr, n_ce, r, g, b, pix_valid, overrun);
    end
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_decode();
    int nl, pc, pe;
    logic [12:0] a;
    logic [5:0] ro, go, bo;
    run_pixel(13'h0010, 8'h8F, 8'h00, 1'b0, 1'b0, nl, pc, pe, a, ro, go, bo);
    vectors++;
    if (a !== 13'h0010) begin miscompares++; $display("FAIL basic_addr: got %h want 0010", a); end
    vectors++;
    if (nl !== 3) begin miscompares++; $display("FAIL basic_nce_cycles: got %0d want 3", nl); end
    vectors++;
    if (pc !== 1 || pe !== 4) begin
      miscompares++; $display("FAIL basic_pix_valid: got count=%0d edge=%0d want 1/4", pc, pe);
    end
    vectors++;
    if ({ro, go, bo} !== {6'h3C, 6'h00, 6'h00}) begin
      miscompares++; $display("FAIL basic_rgb: got %h/%h/%h want 3c/00/00", ro, go, bo);
    end
    vectors++;
    if ({r, g, b} !== {6'h3C, 6'h00, 6'h00}) begin
      miscompares++; $display("FAIL rgb_hold: got %h/%h/%h want 3c/00/00", r, g, b);
    end
    vectors++;
    if (addr !== 13'h0010) begin miscompares++; $display("FAIL addr_hold: got %h want 0010", addr); end
    run_pixel(13'h1ABC, 8'h5A, 8'h3C, 1'b0, 1'b0, nl, pc, pe, a, ro, go, bo);
    vectors++;
    if ({ro, go, bo} !== {6'h2B, 6'h0D, 6'h33} || pe !== 4) begin
      miscompares++; $display("FAIL decode_5a3c: got %h/%h/%h edge=%0d want 2b/0d/33 edge=4", ro, go, bo, pe);
    end
    run_pixel(13'h0001, 8'h00, 8'h00, 1'b0, 1'b0, nl, pc, pe, a, ro, go, bo);
    vectors++;
    if ({ro, go, bo} !== {6'h01, 6'h01, 6'h01}) begin
      miscompares++; $display("FAIL decode_0000: got %h/%h/%h want 01/01/01", ro, go, bo);
    end
  endtask

  task automatic test_back_to_back();
    int pv_seen = 0;
    data_u = 8'h7F; data_l = 8'hFF; blank = 1'b0; shadow = 1'b0;
    for (int e = 0; e < 17; e++) begin
      strobe = (e % 4 == 0) && (e < 16);
      index = 13'(e + 13'h100);
      tick();
      vectors++;
      if (pix_valid !== ((e >= 4) && (e % 4 == 0))) begin
        miscompares++; $display("FAIL b2b_pv_e%0d: got %b", e, pix_valid);
      end
      if (pix_valid) begin
        pv_seen++;
        vectors++;
        if ({r, g, b} !== {6'h3F, 6'h3F, 6'h3F}) begin
          miscompares++; $display("FAIL b2b_rgb_e%0d: got %h/%h/%h want 3f/3f/3f", e, r, g, b);
        end
      end
    end
    strobe = 1'b0;
    vectors++;
    if (pv_seen !== 4 || overrun !== 1'b0) begin
      miscompares++; $display("FAIL b2b_summary: got pixels=%0d ovr=%b want 4/0", pv_seen, overrun);
    end
    tick();
  endtask

  task automatic test_blank();
    int nl, pc, pe;
    logic [12:0] a;
    logic [5:0] ro, go, bo;
    run_pixel(13'h0222, 8'hFF, 8'hFF, 1'b1, 1'b0, nl, pc, pe, a, ro, go, bo);
    vectors++;
    if (nl !== 0) begin miscompares++; $display("FAIL blank_nce: got %0d low cycles want 0", nl); end
    vectors++;
    if (pc !== 1 || pe !== 4 || {ro, go, bo} !== 18'h0) begin
      miscompares++; $display("FAIL blank_rgb: got %h/%h/%h count=%0d edge=%0d want 0/0/0 1/4", ro, go, bo, pc, pe);
    end
  endtask

  task automatic test_overrun();
    int pc = 0;
    vectors++;
    if (overrun !== 1'b0) begin miscompares++; $display("FAIL overrun_pre: got %b want 0", overrun); end
    data_u = 8'h8F; data_l = 8'h00; blank = 1'b0; shadow = 1'b0;
    for (int e = 0; e < 8; e++) begin
      strobe = (e == 0) || (e == 2);
      index  = (e == 0) ? 13'h00AA : 13'h1555;
      tick();
      if (pix_valid) pc++;
    end
    strobe = 1'b0;
    vectors++;
    if (overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_flag: got %b want 1", overrun); end
    vectors++;
    if (pc !== 1) begin miscompares++; $display("FAIL overrun_pv: got %0d pulses want 1", pc); end
    vectors++;
    if (addr !== 13'h00AA) begin miscompares++; $display("FAIL overrun_addr: got %h want 00aa", addr); end
    vectors++;
    if ({r, g, b} !== {6'h3C, 6'h00, 6'h00}) begin
      miscompares++; $display("FAIL overrun_rgb: got %h/%h/%h want 3c/00/00", r, g, b);
    end
  endtask

  task automatic test_shadow();
    int nl, pc, pe;
    logic [12:0] a;
    logic [5:0] ro, go, bo;
    logic [5:0] want;
`ifdef PAL_SHADOW_EN
    want = 6'h1F;
`else
    want = 6'h3F;
`endif
    run_pixel(13'h0333, 8'h7F, 8'hFF, 1'b0, 1'b1, nl, pc, pe, a, ro, go, bo);
    vectors++;
    if ({ro, go, bo} !== {want, want, want} || pe !== 4) begin
      miscompares++; $display("FAIL shadow_rgb: got %h/%h/%h edge=%0d want %h each edge=4", ro, go, bo, pe, want);
    end
  endtask

  task automatic test_reset_fetch();
    int nl, pc, pe;
    int pv_during = 0;
    logic [12:0] a;
    logic [5:0] ro, go, bo;
    index = 13'h0444; data_u = 8'h8F; data_l = 8'h00; blank = 1'b0; strobe = 1'b1;
    tick();
    strobe = 1'b0;
    tick();
    vectors++;
    if (n_ce !== 1'b0) begin miscompares++; $display("FAIL rf_in_fetch: got nce=%b want 0", n_ce); end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({n_ce, r, g, b, pix_valid, overrun, addr} !== {1'b1, 18'h0, 1'b0, 1'b0, 13'h0}) begin
      miscompares++;
      $display("FAIL rf_async: got nce=%b rgb=%h/%h/%h pv=%b ovr=%b addr=%h want 1/0/0/0/0/0/0",
               n_ce, r, g, b, pix_valid, overrun, addr);
    end
    for (int e = 0; e < 4; e++) begin
      tick();
      if (pix_valid) pv_during++;
    end
    #2 rst_n = 1'b1;
    for (int e = 0; e < 4; e++) begin
      tick();
      if (pix_valid) pv_during++;
    end
    vectors++;
    if (pv_during !== 0) begin miscompares++; $display("FAIL rf_no_pv: got %0d pulses want 0", pv_during); end
    run_pixel(13'h0555, 8'h7F, 8'hFF, 1'b0, 1'b0, nl, pc, pe, a, ro, go, bo);
    vectors++;
    if ({ro, go, bo} !== {6'h3F, 6'h3F, 6'h3F} || pe !== 4 || nl !== 3 || a !== 13'h0555) begin
      miscompares++;
      $display("FAIL rf_after: got %h/%h/%h edge=%0d nce_low=%0d addr=%h want 3f each edge=4 nce_low=3 addr=0555",
               ro, go, bo, pe, nl, a);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_blank();
    test_overrun();
    test_shadow();
    test_reset_fetch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
